// File: rtl/dbgnoc_na_output_mc.sv
// dbgnoc_na_output_mc: multi-channel NoC output network adapter.
// Bus writes assemble packets per channel (size word, then flits) into
// per-channel FIFOs; a packet-locked round-robin arbiter drains them onto a
// single valid/ready NoC port.
// Optional feature: define DBGNOC_NA_OUTPUT_STATS_EN for per-channel 16-bit
// completed-packet counters readable at offset 0x1C.
module dbgnoc_na_output_mc #(
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int CHANNELS       = 2,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [31:0]                              bus_addr,
    input  logic                                     bus_en,
    input  logic                                     bus_we,
    input  logic [NOC_DATA_WIDTH-1:0]                bus_data_in,
    output logic [NOC_DATA_WIDTH-1:0]                bus_data_out,
    output logic                                     bus_ack,
    output logic [NOC_DATA_WIDTH+NOC_TYPE_WIDTH-1:0] noc_out_flit,
    output logic                                     noc_out_valid,
    input  logic                                     noc_out_ready
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW  = NOC_DATA_WIDTH + NOC_TYPE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRST   = 2'd1,
        ST_PAYLOAD = 2'd2
    } wr_state_e;

    wr_state_e             state_q  [CHANNELS];
    wr_state_e             state_d  [CHANNELS];
    logic [SW-1:0]         size_q   [CHANNELS];
    logic [SW-1:0]         size_d   [CHANNELS];
    logic                  err_q    [CHANNELS];
    logic                  err_d    [CHANNELS];
    logic [PW-1:0]         wr_ptr_q [CHANNELS];
    logic [PW-1:0]         wr_ptr_d [CHANNELS];
    logic [PW-1:0]         rd_ptr_q [CHANNELS];
    logic [PW-1:0]         rd_ptr_d [CHANNELS];
    logic [SW-1:0]         count_q  [CHANNELS];
    logic [SW-1:0]         count_d  [CHANNELS];
    logic [FW-1:0]         mem_q    [CHANNELS][FIFO_DEPTH];
`ifdef DBGNOC_NA_OUTPUT_STATS_EN
    logic [15:0]           pkt_cnt_q [CHANNELS];
    logic [15:0]           pkt_cnt_d [CHANNELS];
`endif

    logic [CHW-1:0]        grant_q, grant_d;
    logic                  locked_q, locked_d;

    logic [CHANNELS-1:0]   push;
    logic [FW-1:0]         push_flit;
    logic [NOC_TYPE_WIDTH-1:0] ftype;
    logic [CHANNELS-1:0]   nonempty;
    logic [CHANNELS-1:0]   pop_ch;
    logic                  pop;
    logic                  pop_last;
    logic [CHW-1:0]        next_ch;
    logic [CHW:0]          cand;
    logic                  found;

    logic [CHW-1:0]        chan_sel;
    logic                  chan_ok;
    logic                  size_ok;
    logic [31:0]           rd_val;
    logic                  unused_addr;

    assign chan_sel    = bus_addr[6 +: CHW];
    assign chan_ok     = ({1'b0, chan_sel} < (CHW+1)'(CHANNELS));
    assign size_ok     = (bus_data_in != '0) && (bus_data_in <= NOC_DATA_WIDTH'(FIFO_DEPTH));
    assign unused_addr = ^{bus_addr[31:6+CHW], bus_addr[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Per-channel FIFO occupancy flags
    always_comb begin
        nonempty = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            nonempty[c] = (count_q[c] != '0);
        end
    end

    // Bus decode: register reads, size/flit writes and the per-channel write FSMs
    always_comb begin
        bus_ack   = 1'b0;
        rd_val    = '0;
        push_flit = '0;
        ftype     = '0;
        push      = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            size_d[c]  = size_q[c];
            err_d[c]   = err_q[c];
        end
        if (bus_en && !bus_we && bus_addr[4]) begin
            bus_ack = 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (chan_ok && (chan_sel == CHW'(c))) begin
                    case (bus_addr[5:2])
                        4'h4: rd_val[0] = (state_q[c] == ST_IDLE) && (count_q[c] == '0);
                        4'h5: begin
                            rd_val[1:0] = state_q[c];
                            rd_val[31]  = err_q[c];
                            err_d[c]    = 1'b0;
                        end
                        4'h6: rd_val[SW-1:0] = SW'(FIFO_DEPTH) - count_q[c];
`ifdef DBGNOC_NA_OUTPUT_STATS_EN
                        4'h7: rd_val[15:0] = pkt_cnt_q[c];
`endif
                        default: ;
                    endcase
                end
            end
        end else if (bus_en && bus_we) begin
            bus_ack = 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (chan_ok && (chan_sel == CHW'(c)) && !bus_addr[4]) begin
                    case (state_q[c])
                        ST_IDLE: begin
                            if (size_ok) begin
                                state_d[c] = ST_FIRST;
                                size_d[c]  = bus_data_in[SW-1:0];
                            end else begin
                                err_d[c] = 1'b1;
                            end
                        end
                        default: begin
                            // A full FIFO still accepts the flit when its head pops this cycle
                            if ((count_q[c] != SW'(FIFO_DEPTH)) || pop_ch[c]) begin
                                ftype[1]   = (size_q[c] == SW'(1));
                                ftype[0]   = (state_q[c] == ST_FIRST);
                                push[c]    = 1'b1;
                                push_flit  = {ftype, bus_data_in};
                                size_d[c]  = size_q[c] - SW'(1);
                                state_d[c] = (size_q[c] == SW'(1)) ? ST_IDLE : ST_PAYLOAD;
                            end else begin
                                bus_ack = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
        bus_data_out = NOC_DATA_WIDTH'(rd_val);
    end

    // Output port: show-ahead head of the granted FIFO, packet lock and round-robin hand-over
    always_comb begin
        noc_out_valid   = (count_q[grant_q] != '0);
        noc_out_flit    = mem_q[grant_q][rd_ptr_q[grant_q]];
        pop             = noc_out_valid && noc_out_ready;
        pop_last        = pop && noc_out_flit[NOC_DATA_WIDTH+1];
        pop_ch          = '0;
        pop_ch[grant_q] = pop;
        next_ch         = grant_q;
        found           = 1'b0;
        cand            = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            cand = {1'b0, grant_q} + (CHW+1)'(off);
            if (cand >= (CHW+1)'(CHANNELS)) begin
                cand = cand - (CHW+1)'(CHANNELS);
            end
            if (!found && nonempty[cand[CHW-1:0]]) begin
                next_ch = cand[CHW-1:0];
                found   = 1'b1;
            end
        end
        grant_d  = grant_q;
        locked_d = locked_q;
        if (pop) begin
            locked_d = !pop_last;
            if (pop_last) begin
                grant_d = next_ch;
            end
        end else if (!locked_q && !noc_out_valid) begin
            grant_d = next_ch;
        end
    end

    // FIFO pointer/occupancy bookkeeping and optional packet counters
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = push[c]   ? ptr_inc(wr_ptr_q[c]) : wr_ptr_q[c];
            rd_ptr_d[c] = pop_ch[c] ? ptr_inc(rd_ptr_q[c]) : rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (push[c] && !pop_ch[c]) begin
                count_d[c] = count_q[c] + SW'(1);
            end else if (!push[c] && pop_ch[c]) begin
                count_d[c] = count_q[c] - SW'(1);
            end
`ifdef DBGNOC_NA_OUTPUT_STATS_EN
            pkt_cnt_d[c] = (pop_ch[c] && pop_last) ? pkt_cnt_q[c] + 16'd1 : pkt_cnt_q[c];
`endif
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= ST_IDLE;
                err_q[c]    <= 1'b0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
`ifdef DBGNOC_NA_OUTPUT_STATS_EN
                pkt_cnt_q[c] <= '0;
`endif
            end
            grant_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= state_d[c];
                err_q[c]    <= err_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
`ifdef DBGNOC_NA_OUTPUT_STATS_EN
                pkt_cnt_q[c] <= pkt_cnt_d[c];
`endif
            end
            grant_q  <= grant_d;
            locked_q <= locked_d;
        end
    end

    // Unreset storage: remaining packet sizes and FIFO contents
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            size_q[c] <= size_d[c];
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= push_flit;
            end
        end
    end

endmodule

// File: tb/tb_dbgnoc_na_output_mc.sv
// Directed bench for dbgnoc_na_output_mc with default parameters
// (32-bit data, 2 channels, 16-deep FIFOs).
module tb_dbgnoc_na_output_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr;
    logic        bus_en;
    logic        bus_we;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_ack;
    logic [33:0] noc_out_flit;
    logic        noc_out_valid;
    logic        noc_out_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef DBGNOC_NA_OUTPUT_STATS_EN
    localparam int EXP_PKTS = 3;
`else
    localparam int EXP_PKTS = 0;
`endif

    always #5 clk = ~clk;

    dbgnoc_na_output_mc #(
        .NOC_DATA_WIDTH(32),
        .NOC_TYPE_WIDTH(2),
        .CHANNELS(2),
        .FIFO_DEPTH(16)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_addr(bus_addr),
        .bus_en(bus_en),
        .bus_we(bus_we),
        .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out),
        .bus_ack(bus_ack),
        .noc_out_flit(noc_out_flit),
        .noc_out_valid(noc_out_valid),
        .noc_out_ready(noc_out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int unsigned ch, input logic [5:0] off);
        return (32'(ch) << 6) | {26'b0, off};
    endfunction

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, output logic ack);
        @(negedge clk);
        bus_en      = 1'b1;
        bus_we      = 1'b1;
        bus_addr    = addr;
        bus_data_in = data;
        #1 ack = bus_ack;
        @(posedge clk);
        #1 bus_en = 1'b0;
        bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic ack);
        @(negedge clk);
        bus_en   = 1'b1;
        bus_we   = 1'b0;
        bus_addr = addr;
        #1 data = bus_data_out;
        ack = bus_ack;
        @(posedge clk);
        #1 bus_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ack;
        logic [31:0] rdata;
        int          n_ack;
        logic [33:0] exp_seq [6];

        rst_n         = 1'b0;
        bus_en        = 1'b0;
        bus_we        = 1'b0;
        bus_addr      = '0;
        bus_data_in   = '0;
        noc_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_valid", noc_out_valid, 1'b0);
        bus_rd(ra(0, 6'h10), rdata, ack);
        check_eq("rst_empty", rdata, 32'h1);
        bus_rd(ra(0, 6'h14), rdata, ack);
        check_eq("rst_state", rdata, 32'h0);
        bus_rd(ra(0, 6'h18), rdata, ack);
        check_eq("rst_free", rdata, 32'd16);
        bus_rd(ra(0, 6'h00), rdata, ack);
        check_eq("rd_low_noack", ack, 1'b0);

        // Single-flit packet on ch0, one cycle push-to-output
        noc_out_ready = 1'b1;
        bus_wr(ra(0, 6'h00), 32'd1, ack);
        check_eq("single_size_ack", ack, 1'b1);
        bus_wr(ra(0, 6'h00), 32'hCAFE_0001, ack);
        check_eq("single_flit_ack", ack, 1'b1);
        @(negedge clk);
        check_eq("single_valid", noc_out_valid, 1'b1);
        check_eq("single_flit", noc_out_flit, {2'b11, 32'hCAFE_0001});
        bus_rd(ra(0, 6'h10), rdata, ack);
        check_eq("single_empty", rdata, 32'h1);
        check_eq("single_after_valid", noc_out_valid, 1'b0);
        noc_out_ready = 1'b0;

        // Three-flit packet on ch1 with stall
        bus_wr(ra(1, 6'h00), 32'd3, ack);
        bus_wr(ra(1, 6'h00), 32'hA1A1_0001, ack);
        bus_wr(ra(1, 6'h00), 32'hA1A1_0002, ack);
        bus_wr(ra(1, 6'h00), 32'hA1A1_0003, ack);
        @(negedge clk);
        check_eq("stall_valid", noc_out_valid, 1'b1);
        check_eq("stall_head", noc_out_flit, {2'b01, 32'hA1A1_0001});
        @(negedge clk);
        check_eq("stall_hold", {noc_out_valid, noc_out_flit}, {1'b1, 2'b01, 32'hA1A1_0001});
        noc_out_ready = 1'b1;
        @(negedge clk);
        check_eq("pkt3_payload", noc_out_flit, {2'b00, 32'hA1A1_0002});
        @(negedge clk);
        check_eq("pkt3_last", noc_out_flit, {2'b10, 32'hA1A1_0003});
        @(negedge clk);
        check_eq("pkt3_done", noc_out_valid, 1'b0);
        noc_out_ready = 1'b0;

        // Two channels with queued packets: no interleaving, round-robin order
        n_ack = 0;
        bus_wr(ra(0, 6'h00), 32'd2, ack);          n_ack += int'(ack);
        bus_wr(ra(0, 6'h00), 32'h00C0_0001, ack);  n_ack += int'(ack);
        bus_wr(ra(0, 6'h00), 32'h00C0_0002, ack);  n_ack += int'(ack);
        bus_wr(ra(1, 6'h00), 32'd2, ack);          n_ack += int'(ack);
        bus_wr(ra(1, 6'h00), 32'h00C1_0001, ack);  n_ack += int'(ack);
        bus_wr(ra(1, 6'h00), 32'h00C1_0002, ack);  n_ack += int'(ack);
        bus_wr(ra(0, 6'h00), 32'd2, ack);          n_ack += int'(ack);
        bus_wr(ra(0, 6'h00), 32'h00C0_0003, ack);  n_ack += int'(ack);
        bus_wr(ra(0, 6'h00), 32'h00C0_0004, ack);  n_ack += int'(ack);
        check_eq("rr_acks", n_ack, 9);
        exp_seq[0] = {2'b01, 32'h00C0_0001};
        exp_seq[1] = {2'b10, 32'h00C0_0002};
        exp_seq[2] = {2'b01, 32'h00C1_0001};
        exp_seq[3] = {2'b10, 32'h00C1_0002};
        exp_seq[4] = {2'b01, 32'h00C0_0003};
        exp_seq[5] = {2'b10, 32'h00C0_0004};
        @(negedge clk);
        noc_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_flit%0d", i), {noc_out_valid, noc_out_flit}, {1'b1, exp_seq[i]});
            @(negedge clk);
        end
        check_eq("rr_done", noc_out_valid, 1'b0);
        noc_out_ready = 1'b0;

        // Fill ch0 FIFO to capacity, then push while full
        n_ack = 0;
        bus_wr(ra(0, 6'h00), 32'd16, ack);
        n_ack += int'(ack);
        for (int i = 0; i < 16; i++) begin
            bus_wr(ra(0, 6'h00), 32'h4000_0000 + 32'(i), ack);
            n_ack += int'(ack);
        end
        check_eq("fill_acks", n_ack, 17);
        bus_rd(ra(0, 6'h18), rdata, ack);
        check_eq("fill_free", rdata, 32'd0);
        bus_rd(ra(0, 6'h10), rdata, ack);
        check_eq("fill_empty", rdata, 32'd0);
        bus_wr(ra(0, 6'h00), 32'd1, ack);
        check_eq("full_size_ack", ack, 1'b1);
        @(negedge clk);
        bus_en      = 1'b1;
        bus_we      = 1'b1;
        bus_addr    = ra(0, 6'h00);
        bus_data_in = 32'h4000_00FF;
        #1 check_eq("full_stall_ack0", bus_ack, 1'b0);
        @(negedge clk);
        #1 check_eq("full_stall_ack1", bus_ack, 1'b0);
        noc_out_ready = 1'b1;
        #1 check_eq("full_pushpop_ack", bus_ack, 1'b1);
        check_eq("full_head", {noc_out_valid, noc_out_flit}, {1'b1, 2'b01, 32'h4000_0000});
        @(posedge clk);
        #1 bus_en = 1'b0;
        bus_we = 1'b0;
        repeat (20) @(negedge clk);
        bus_rd(ra(0, 6'h10), rdata, ack);
        check_eq("drain_empty", rdata, 32'h1);
        bus_rd(ra(0, 6'h18), rdata, ack);
        check_eq("drain_free", rdata, 32'd16);
        noc_out_ready = 1'b0;

        // Illegal sizes set the sticky error flag, cleared by reading it
        bus_wr(ra(1, 6'h00), 32'd0, ack);
        check_eq("size0_ack", ack, 1'b1);
        bus_rd(ra(1, 6'h14), rdata, ack);
        check_eq("size0_err", rdata, 32'h8000_0000);
        bus_rd(ra(1, 6'h14), rdata, ack);
        check_eq("size0_clr", rdata, 32'h0);
        bus_wr(ra(1, 6'h00), 32'd17, ack);
        check_eq("size17_ack", ack, 1'b1);
        bus_rd(ra(1, 6'h14), rdata, ack);
        check_eq("size17_err", rdata, 32'h8000_0000);
        check_eq("size17_rd_ack", ack, 1'b1);
        bus_rd(ra(1, 6'h14), rdata, ack);
        check_eq("size17_clr", rdata, 32'h0);

        // Reset after 2 of 3 flits discards the partial packet
        bus_wr(ra(0, 6'h00), 32'd3, ack);
        bus_wr(ra(0, 6'h00), 32'h0BAD_0001, ack);
        bus_wr(ra(0, 6'h00), 32'h0BAD_0002, ack);
        @(negedge clk);
        check_eq("prerst_valid", noc_out_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", noc_out_valid, 1'b0);
        rst_n = 1'b1;
        bus_rd(ra(0, 6'h14), rdata, ack);
        check_eq("midrst_state", rdata, 32'h0);
        bus_rd(ra(0, 6'h18), rdata, ack);
        check_eq("midrst_free", rdata, 32'd16);
        noc_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_quiet", noc_out_valid, 1'b0);

        // Three single-flit packets on ch1 for the packet counter
        for (int i = 0; i < 3; i++) begin
            bus_wr(ra(1, 6'h00), 32'd1, ack);
            bus_wr(ra(1, 6'h00), 32'h5000_0000 + 32'(i), ack);
        end
        repeat (6) @(negedge clk);
        bus_rd(ra(1, 6'h1C), rdata, ack);
        check_eq("stats_ch1", rdata, 32'(EXP_PKTS));
        check_eq("stats_ack", ack, 1'b1);
        bus_rd(ra(0, 6'h1C), rdata, ack);
        check_eq("stats_ch0", rdata, 32'h0);
        bus_rd(ra(1, 6'h10), rdata, ack);
        check_eq("stats_empty", rdata, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
